// File: rtl/ntt_butterfly_if.sv
// Beat bus between the coefficient read port, the NTT butterfly and the write-back path.
// Coefficient width and modulus come from global defines; Kyber values are the fallback.
`ifndef DATA_WIDTH
`define DATA_WIDTH 12
`endif
`ifndef Q
`define Q 3329
`endif

interface ntt_butterfly_if;
  logic                   in_valid;
  logic                   mode;
  logic [`DATA_WIDTH-1:0] a;
  logic [`DATA_WIDTH-1:0] b;
  logic [`DATA_WIDTH-1:0] w;
  logic                   out_valid;
  logic [`DATA_WIDTH-1:0] out0;
  logic [`DATA_WIDTH-1:0] out1;
  logic                   busy;

  modport master (
    output in_valid, mode, a, b, w,
    input  out_valid, out0, out1, busy
  );

  modport slave (
    input  in_valid, mode, a, b, w,
    output out_valid, out0, out1, busy
  );
endinterface

// File: rtl/ntt_butterfly.sv
// Pipelined CT/GS NTT butterfly around a bit-serial Montgomery multiplier; one beat per clock
// and the same in_valid -> out_valid latency in both modes.
`ifndef DATA_WIDTH
`define DATA_WIDTH 12
`endif
`ifndef Q
`define Q 3329
`endif

module ntt_butterfly (
  input  logic           clk,
  input  logic           rst_n,
  ntt_butterfly_if.slave bus
);
  localparam int unsigned DW      = `DATA_WIDTH;
  localparam int unsigned LATENCY = DW + 4;
  localparam int unsigned MulLat  = DW + 2;

  localparam logic [DW-1:0] QDw  = DW'(`Q);
  localparam logic [DW:0]   QExt = {1'b0, QDw};
  localparam logic [DW+1:0] QMul = {2'b00, QDw};

  function automatic logic [DW-1:0] add_mod(input logic [DW-1:0] x, input logic [DW-1:0] y);
    logic [DW:0] s;
    s = {1'b0, x} + {1'b0, y};
    return DW'((s >= QExt) ? s - QExt : s);
  endfunction

  function automatic logic [DW-1:0] sub_mod(input logic [DW-1:0] x, input logic [DW-1:0] y);
    return (x >= y) ? x - y : DW'({1'b0, x} + QExt - {1'b0, y});
  endfunction

  logic [LATENCY-1:0] vld_q;
  logic               mode_q;
  logic               mode_eff;
  logic               busy;
  logic [DW-1:0]      out0_q, out1_q;

  logic [DW-1:0] gs_sum_q, gs_diff_q, gs_w_q;
  logic [DW-1:0] mul_a, mul_b;
  logic [DW-1:0] mm_a_q [DW];
  logic [DW-1:0] mm_b_q [DW];
  logic [DW+1:0] mm_t_q [DW+1];
  logic [DW+1:0] mm_t_d [DW];
  logic [DW-1:0] prod_q;
  logic [DW-1:0] dly_q [MulLat];
  logic [DW-1:0] ct0_q, ct1_q;
  logic [DW-1:0] a_late, gs_prod;

  // Mode is frozen while anything is in flight so the shared multiplier never mixes modes.
  assign busy     = |vld_q;
  assign mode_eff = busy ? mode_q : bus.mode;

  // CT multiplies the live inputs; GS multiplies the registered difference one cycle later.
  assign mul_a   = mode_eff ? gs_w_q : bus.w;
  assign mul_b   = mode_eff ? gs_diff_q : bus.b;
  assign a_late  = dly_q[MulLat-1];
  assign gs_prod = (prod_q == QDw) ? '0 : prod_q;

  // One Montgomery step per stage: t = (t + b[k]*a + m*Q) / 2, with t kept below 2Q.
  always_comb begin
    logic [DW+1:0] acc;
    acc = '0;
    for (int k = 0; k < DW; k++) begin
      acc = mm_t_q[k] + (mm_b_q[k][k] ? {2'b00, mm_a_q[k]} : '0);
      if (acc[0]) acc = acc + QMul;
      mm_t_d[k] = acc >> 1;
    end
  end

  always_ff @(posedge clk) begin
    gs_sum_q  <= add_mod(bus.a, bus.b);
    gs_diff_q <= sub_mod(bus.a, bus.b);
    gs_w_q    <= bus.w;
    mm_a_q[0] <= mul_a;
    mm_b_q[0] <= mul_b;
    mm_t_q[0] <= '0;
    for (int k = 1; k < DW; k++) begin
      mm_a_q[k] <= mm_a_q[k-1];
      mm_b_q[k] <= mm_b_q[k-1];
    end
    for (int k = 0; k < DW; k++) mm_t_q[k+1] <= mm_t_d[k];
    prod_q <= DW'((mm_t_q[DW] >= QMul) ? mm_t_q[DW] - QMul : mm_t_q[DW]);
    // Shared delay line: raw a for CT, reduced a+b for GS (entered one cycle later).
    dly_q[0] <= mode_eff ? gs_sum_q : bus.a;
    for (int k = 1; k < MulLat; k++) dly_q[k] <= dly_q[k-1];
    ct0_q <= add_mod(a_late, prod_q);
    ct1_q <= sub_mod(a_late, prod_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      mode_q <= 1'b0;
      out0_q <= '0;
      out1_q <= '0;
    end else begin
      vld_q  <= {vld_q[LATENCY-2:0], bus.in_valid};
      mode_q <= mode_eff;
      if (vld_q[LATENCY-2]) begin
        out0_q <= mode_q ? a_late : ct0_q;
        out1_q <= mode_q ? gs_prod : ct1_q;
      end
    end
  end

  assign bus.out_valid = vld_q[LATENCY-1];
  assign bus.out0      = out0_q;
  assign bus.out1      = out1_q;
  assign bus.busy      = busy;

endmodule
